// File: rtl/noc_pkg.sv
// Shared NoC router definitions: default packet width and the packet type.
package noc_pkg;

  localparam int unsigned PAC_WIDTH = 64;

  typedef logic [PAC_WIDTH-1:0] packet_t;

endpackage : noc_pkg

// File: rtl/packet_buffer.sv
// First-word-fall-through packet buffer for NoC router input ports.
// Holds up to DEPTH packets in a flop array. The head packet is presented
// combinationally on d_out. full/empty are decoded from the occupancy count.
module packet_buffer
  import noc_pkg::*;
#(
  parameter int unsigned PAC_WIDTH = noc_pkg::PAC_WIDTH,
  parameter int unsigned DEPTH     = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wen,
  input  logic                 ren,
  input  logic [PAC_WIDTH-1:0] d_in,
  output logic                 full,
  output logic                 empty,
  output logic [PAC_WIDTH-1:0] d_out
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef logic [PAC_WIDTH-1:0] pkt_t;

  pkt_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_wr_ok;
  logic w_ren_ok;

  // With a single slot both pointers stay at 0; otherwise they wrap naturally
  // because DEPTH is a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (DEPTH == 1) begin
      return '0;
    end else begin
      return PTR_W'(p + 1'b1);
    end
  endfunction

  // Status flags and transfer acceptance; a write while full is still taken
  // when a read frees a slot on the same edge.
  always_comb begin
    w_empty  = (r_count == '0);
    w_full   = (r_count == CNT_W'(DEPTH));
    w_ren_ok = ren & ~w_empty;
    w_wr_ok  = wen & (~w_full | w_ren_ok);
  end

  // Storage array: cleared on reset, written at the write pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_mem[r_wr_ptr] <= d_in;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_ren_ok) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_wr_ok, w_ren_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Outputs: head packet falls through; stale when empty.
  always_comb begin
    full  = w_full;
    empty = w_empty;
    d_out = r_mem[r_rd_ptr];
  end

endmodule : packet_buffer

// File: tb/tb_packet_buffer.sv
// Self-checking bench for packet_buffer: one-slot and four-slot instances
// share stimulus; a queue model is compared on every falling edge and
// directed literal checks pin the expected behaviour.
module tb_packet_buffer;
  import noc_pkg::*;

  logic    clk = 1'b0;
  logic    reset = 1'b0;
  logic    wen = 1'b0;
  logic    ren = 1'b0;
  packet_t d_in = '0;

  logic    full1, empty1, full4, empty4;
  packet_t d_out1, d_out4;

  int total = 0;
  int bad   = 0;

  packet_buffer #(.PAC_WIDTH(64), .DEPTH(1)) u_dut1 (
    .clk(clk), .reset(reset), .wen(wen), .ren(ren), .d_in(d_in),
    .full(full1), .empty(empty1), .d_out(d_out1)
  );

  packet_buffer #(.PAC_WIDTH(64), .DEPTH(4)) u_dut4 (
    .clk(clk), .reset(reset), .wen(wen), .ren(ren), .d_in(d_in),
    .full(full4), .empty(empty4), .d_out(d_out4)
  );

  always #5 clk = ~clk;

  // Behavioural model: bounded queues, one per instance.
  packet_t q1[$];
  packet_t q4[$];
  bit      model_valid = 1'b0;

  task automatic model_step(inout packet_t q[$], input int cap);
    bit rd, wr;
    rd = ren && (q.size() > 0);
    wr = wen && ((q.size() < cap) || rd);
    if (rd) void'(q.pop_front());
    if (wr) q.push_back(d_in);
  endtask

  always @(posedge clk) begin
    if (reset) begin
      q1.delete();
      q4.delete();
      model_valid <= 1'b1;
    end else if (model_valid) begin
      model_step(q1, 1);
      model_step(q4, 4);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous compare against the queue model.
  always @(negedge clk) begin
    if (model_valid) begin
      chk("m1_empty", 64'(empty1), 64'(q1.size() == 0));
      chk("m1_full",  64'(full1),  64'(q1.size() == 1));
      if (q1.size() > 0) chk("m1_dout", d_out1, q1[0]);
      chk("m4_empty", 64'(empty4), 64'(q4.size() == 0));
      chk("m4_full",  64'(full4),  64'(q4.size() == 4));
      if (q4.size() > 0) chk("m4_dout", d_out4, q4[0]);
    end
  end

  task automatic step(input logic r, input logic w, input logic rd, input packet_t d);
    reset = r;
    wen   = w;
    ren   = rd;
    d_in  = d;
    @(posedge clk);
    #1;
    reset = 1'b0;
    wen   = 1'b0;
    ren   = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    #1;

    // Reset
    step(1, 0, 0, 64'h0);
    chk("rst_empty", 64'(empty1), 64'd1);
    chk("rst_full",  64'(full1),  64'd0);
    chk("rst_dout",  d_out1,      64'h0);
    chk("rst_dout4", d_out4,      64'h0);

    // Single write falls through immediately
    step(0, 1, 0, 64'hDEADBEEF_01234567);
    chk("wr_full",  64'(full1),  64'd1);
    chk("wr_empty", 64'(empty1), 64'd0);
    chk("wr_dout",  d_out1,      64'hDEADBEEF_01234567);

    // Hold for three idle cycles
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 64'h0);
      chk("hold_dout", d_out1, 64'hDEADBEEF_01234567);
    end

    // Read, then a read while empty is ignored; d_out stays stale
    step(0, 0, 1, 64'h0);
    chk("rd_empty", 64'(empty1), 64'd1);
    chk("rd_full",  64'(full1),  64'd0);
    step(0, 0, 1, 64'h0);
    chk("rd2_empty", 64'(empty1), 64'd1);
    chk("rd2_stale", d_out1,      64'hDEADBEEF_01234567);
    chk("rd2_empty4", 64'(empty4), 64'd1);

    // Overflow: further writes dropped on the one-slot buffer
    step(0, 1, 0, 64'h1111_2222_3333_4444);
    chk("ovf_full", 64'(full1), 64'd1);
    step(0, 1, 0, 64'hAAAA_BBBB_CCCC_DDDD);
    chk("ovf_dout_a", d_out1, 64'h1111_2222_3333_4444);
    step(0, 1, 0, 64'h5555_6666_7777_8888);
    chk("ovf_dout_b", d_out1, 64'h1111_2222_3333_4444);
    chk("ovf_full_b", 64'(full1), 64'd1);
    chk("ovf_full4",  64'(full4), 64'd0);

    // Simultaneous read/write while full and while empty
    step(1, 0, 0, 64'h0);
    step(0, 1, 0, 64'h1);
    step(0, 1, 1, 64'h2);
    chk("sim_full", 64'(full1), 64'd1);
    chk("sim_dout", d_out1,     64'h2);
    step(0, 0, 1, 64'h0);
    chk("sim_rd_empty", 64'(empty1), 64'd1);
    step(0, 1, 1, 64'h77);
    chk("sim_e_empty", 64'(empty1), 64'd0);
    chk("sim_e_dout",  d_out1,      64'h77);

    // Mid-operation reset with a write pending
    step(1, 1, 0, 64'h99);
    chk("mrst_empty", 64'(empty1), 64'd1);
    chk("mrst_full",  64'(full1),  64'd0);
    chk("mrst_dout",  d_out1,      64'h0);
    chk("mrst_dout4", d_out4,      64'h0);

    // Four-slot buffer: fill, drop, drain in order
    for (int i = 0; i < 4; i++) step(0, 1, 0, 64'(64'h10 + i));
    chk("d4_full", 64'(full4), 64'd1);
    step(0, 1, 0, 64'hEE);
    chk("d4_drop_full", 64'(full4), 64'd1);
    for (int i = 0; i < 4; i++) begin
      chk("d4_order", d_out4, 64'(64'h10 + i));
      step(0, 0, 1, 64'h0);
    end
    chk("d4_drained", 64'(empty4), 64'd1);

    // Pointer wrap across ten write/read pairs, with a simultaneous
    // read/write at partial occupancy
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 0, 64'(64'hA00 + i));
      chk("wrap_dout", d_out4, 64'(64'hA00 + i));
      step(0, 0, 1, 64'h0);
    end
    step(0, 1, 0, 64'hB0);
    step(0, 1, 0, 64'hB1);
    step(0, 1, 1, 64'hB2);
    chk("part_dout", d_out4, 64'hB1);
    step(0, 0, 1, 64'h0);
    chk("part_dout2", d_out4, 64'hB2);
    step(0, 0, 0, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_packet_buffer

// File: doc/packet_buffer.md
Name: packet_buffer

Overview:
- Single-clock, parameterised first-word-fall-through (FWFT) packet buffer used at NoC router input ports.
- Holds up to DEPTH packets of PAC_WIDTH bits.
- Reports full/empty status to the upstream link and router control.
- Default DEPTH=1 gives the router's one-packet input slot: one write makes it full, and further writes are dropped until a read frees the slot.

Parameters:
- PAC_WIDTH, 64, packet width in bits (d_in/d_out).
- DEPTH, 1, number of packet entries; must be a power of two and >= 1.
- PTR_W, max(1,$clog2(DEPTH)), derived localparam: pointer width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- wen  input  1  write request; d_in is captured on the clk edge if accepted.
- ren  input  1  read request; pops the head entry on the clk edge if accepted.
- d_in  input  PAC_WIDTH  packet to write.
- full  output  1  high when count == DEPTH.
- empty  output  1  high when count == 0.
- d_out  output  PAC_WIDTH  head-of-queue packet (FWFT), combinational from storage.

Behaviour:
- State: storage mem[DEPTH], wr_ptr, rd_ptr (PTR_W bits, wrap modulo DEPTH), count (0..DEPTH, $clog2(DEPTH+1) bits).
  - For DEPTH=1 the pointers are constant 0.
- Reset (clk edge with reset=1), overriding wen/ren:
  - wr_ptr, rd_ptr and count go to 0.
  - All storage entries are cleared to 0.
  - Result: empty=1, full=0, d_out=0.
- Flags are combinational from count: empty=(count==0), full=(count==DEPTH).
- Write acceptance: wr_ok = wen & (~full | ren_ok).
  - On wr_ok: mem[wr_ptr] <= d_in, and wr_ptr increments with wrap.
  - A write while full without a simultaneous read is dropped silently; storage and pointers are unchanged.
- Read acceptance: ren_ok = ren & ~empty.
  - On ren_ok: rd_ptr increments with wrap.
  - A read while empty is ignored.
- Count update: +1 if wr_ok & ~ren_ok; -1 if ren_ok & ~wr_ok; unchanged otherwise.
- d_out = mem[rd_ptr].
  - Latency: a packet written at edge N appears on d_out, with empty=0, immediately after edge N.
  - When empty, d_out keeps showing the last entry at rd_ptr (stale, no clear); consumers must qualify d_out with ~empty.
- Simultaneous wen & ren:
  - Full: both accepted, the new packet replaces the freed slot, count unchanged. For DEPTH=1, d_out shows the new packet after the edge.
  - Empty: write accepted, read ignored, count becomes 1.
  - Otherwise: both accepted, count unchanged.
- Reset asserted mid-operation discards all contents on that edge, regardless of wen/ren.
- No X propagation: flags are valid from the first reset onward.

Decomposition:
- Shared package noc_pkg holds PAC_WIDTH default (64) and the packet typedef logic [PAC_WIDTH-1:0] used across router blocks.
- No sub-module is needed: pointer and count logic plus the storage array live in this module.
- Storage is a flop array, not a RAM macro.

Test Plan:
- Reset: hold reset=1 for 1 cycle -> empty=1, full=0, d_out=64'h0.
- Single write: wen=1, d_in=64'hDEADBEEF_01234567 for one cycle -> next cycle full=1, empty=0, d_out=64'hDEADBEEF_01234567.
- Hold/read: idle 3 cycles (d_out stable), then ren=1 for 2 cycles -> after first edge empty=1, full=0. The second read is ignored and count stays 0.
- Overflow drop: write 64'h1111_2222_3333_4444 (full), then keep wen=1 with d_in changing to 64'hAAAA_BBBB_CCCC_DDDD and 64'h5555_6666_7777_8888 -> d_out remains 64'h1111_2222_3333_4444 and full stays 1.
- Simultaneous: while full with 64'h1, assert wen=1 (d_in=64'h2) and ren=1 -> full stays 1, d_out=64'h2. While empty with both asserted -> empty=0, d_out=d_in.
- Mid-op reset: while full, assert reset with wen=1 -> empty=1, full=0, d_out=0. With DEPTH=4: 4 writes -> full=1; 4 reads in FIFO order; pointer wrap verified over 10 writes/reads.
